apb_timer_evt: RTL
==================

APB_TIMER_EVT -- requirements
Module: apb_timer_evt

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter/compare/capture width (8..32).
REQ-002 SHALL have ports:
- HCLK  in  1  processor clock; all logic on its rising edge.
- HRESETn  in  1  system reset, asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  5  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  access to an unmapped address.
- stoptimer_i  in  1  level; freezes counter while high.
- event_lo_i  in  1  asynchronous count event.
- event_hi_i  in  1  asynchronous capture event.
- busy_o  out  1  timer enabled and not stopped.
- irq_o  out  1  compare-match or overflow interrupt, level.

Function
REQ-003 Register map SHALL be: 0x00 CTRL (RW: [0] EN, [1] SRC 0=HCLK/1=event_lo, [2] ONESHOT, [3] IRQ_EN, [15:8] PRESC), 0x04 CNT (RW), 0x08 CMP (RW, reset all-ones), 0x0C CAP (RO), 0x10 STATUS (W1C: [0] MATCH, [1] OVF, [2] CAPV).
- Unused bits read 0.
- CNT/CMP/CAP are zero-extended to 32 bits.
REQ-004 Access handling:
- Write commits in the ACCESS phase (PSEL & PENABLE & PWRITE).
- Read data is valid in the ACCESS phase.
- Any address above 0x10 asserts PSLVERR for that ACCESS cycle; writes are ignored and reads return 0.
REQ-005 event_lo_i and event_hi_i SHALL each pass through a 2-flop synchronizer plus rising-edge detector. Edge-to-pulse latency is 3 HCLK cycles.
REQ-006 Tick generation:
- SRC=0: tick when the prescale counter equals PRESC, then the prescale counter clears to 0.
- SRC=1: tick on each event_lo edge pulse.
REQ-007 On a tick with EN=1 and stoptimer_i=0, CNT SHALL increment by 1 modulo 2^CNT_W.
REQ-008 stoptimer_i=1 SHALL hold both CNT and the prescale counter. Ticks arriving while stopped are dropped, not queued.
REQ-009 When CNT==CMP on a counting tick:
- Next CNT is 0.
- MATCH sets.
- If ONESHOT=1, EN clears in the same cycle.
REQ-010 When CNT wraps from all-ones to 0 without a match, OVF SHALL set.
REQ-011 An event_hi edge pulse SHALL load CAP with the current CNT and set CAPV, regardless of EN.
REQ-012 A capture pulse and a software read of CAP in the same cycle: the read SHALL return the old CAP.
REQ-013 State machine IDLE/RUN/HALT, registered:
- IDLE->RUN when EN=1.
- RUN->HALT when stoptimer_i=1.
- HALT->RUN when stoptimer_i=0.
- Any state->IDLE when EN=0.
REQ-014 busy_o SHALL be 1 exactly in RUN, registered (1 cycle after the causing edge).
REQ-015 irq_o SHALL equal IRQ_EN & (MATCH | OVF), registered.
REQ-016 A software CNT write SHALL take priority over a same-cycle increment. A write to CNT also clears the prescale counter.
REQ-017 When hardware sets a STATUS bit in the same cycle as a W1C write to that bit, the set SHALL win.

Reset
REQ-018 Asynchronous assertion of HRESETn=0 SHALL immediately force:
- CTRL=0, CNT=0, CAP=0, STATUS=0, CMP=all-ones.
- Prescale counter=0, state IDLE, synchronizer flops 0.
- PRDATA=0, PSLVERR=0, busy_o=0, irq_o=0.
REQ-019 Reset deassertion SHALL be used unsynchronized inside the block; the integrator synchronizes it upstream.
REQ-020 Reset mid-count SHALL discard all state, with no pending tick or capture surviving.

Configuration
REQ-021 Macro APB_TIMER_EVT_PRESCALER_EN:
- Defined: PRESC is implemented as in REQ-003 and REQ-006.
- Undefined: PRESC bits read 0, writes are ignored, and SRC=0 ticks every HCLK cycle.

Structure
REQ-022 Package apb_timer_evt_pkg SHALL hold:
- Register offset constants and the CTRL/STATUS bit-index constants.
- The state enum typedef (IDLE/RUN/HALT).
- The CMP reset value function of CNT_W.
REQ-023 Sub-module apb_timer_evt_sync SHALL implement one synchronizer plus edge detector; it is instantiated twice.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- CTRL=0x01, CMP=4, PRESC=0 -> MATCH set and CNT=0 after the 5th tick; irq_o stays 0 (IRQ_EN=0).
- CTRL=0x0F (event_lo source, oneshot, IRQ_EN), CMP=2, 3 event_lo pulses -> irq_o=1, EN=0, busy_o=0; a 4th pulse leaves CNT=0.
- Running, CNT=10, stoptimer_i high for 20 cycles -> CNT holds 10, busy_o=0 from 1 cycle after assertion, resumes afterwards.
- CNT=0x55, event_hi pulse -> CAP=0x55 and CAPV=1 three cycles later; writing 0x4 to STATUS clears CAPV.
- Read of 0x14 -> PSLVERR=1 and PRDATA=0; a CNT write plus tick in the same cycle -> CNT equals the written value.
- HRESETn pulsed low mid-count -> all outputs 0 and CMP=all-ones with no clock edge required.

Source files
------------

// File: rtl/apb_timer_evt_pkg.sv
// Shared register offsets, control/status bit positions, FSM state type and
// the compare-register reset value for the APB event timer.
package apb_timer_evt_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_CNT    = 5'h04;
  localparam logic [4:0] OFF_CMP    = 5'h08;
  localparam logic [4:0] OFF_CAP    = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_SRC       = 1;
  localparam int CTRL_ONESHOT   = 2;
  localparam int CTRL_IRQ_EN    = 3;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_CAPV  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } tmr_state_t;

  function automatic logic [31:0] cmp_rst_val(input int unsigned cnt_w);
    return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/apb_timer_evt_if.sv
// APB3 slave bus bundle for the event timer; zero-wait-state, so PREADY is
// driven constant high by the slave and no backpressure is ever applied.
interface apb_timer_evt_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_evt_sync.sv
// Two-flop synchronizer plus rising-edge detector producing a one-cycle pulse.
// An input edge acts on the third HCLK rising edge; no backpressure.
module apb_timer_evt_sync (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic din,
  output logic pulse
);

  // [1:0] are the synchronizer stages, [2] holds the previous synced level
  logic [2:0] sh;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/apb_timer_evt.sv
// APB3 timer/counter with event count, capture, compare-match and overflow irq.
// Zero-wait-state APB, no backpressure; prescaler built only with APB_TIMER_EVT_PRESCALER_EN.
module apb_timer_evt
  import apb_timer_evt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  apb_timer_evt_if.slave apb,
  input  logic           stoptimer_i,
  input  logic           event_lo_i,
  input  logic           event_hi_i,
  output logic           busy_o,
  output logic           irq_o
);

  localparam logic [31:0]      CMP_RST32 = cmp_rst_val(CNT_W);
  localparam logic [CNT_W-1:0] CMP_RST   = CMP_RST32[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       W_CTRL    = OFF_CTRL[4:2];
  localparam logic [2:0]       W_CNT     = OFF_CNT[4:2];
  localparam logic [2:0]       W_CMP     = OFF_CMP[4:2];
  localparam logic [2:0]       W_CAP     = OFF_CAP[4:2];
  localparam logic [2:0]       W_STATUS  = OFF_STATUS[4:2];

  logic             ctrl_en, ctrl_src, ctrl_oneshot, ctrl_irq_en;
  logic [CNT_W-1:0] cnt, cmp, cap;
  logic [2:0]       status, st_set, st_clr;
  logic [7:0]       presc_rd;
  logic             lo_pulse, hi_pulse, hclk_tick, tick, count, hit, wrap;
  logic             busy_q, irq_q;
  tmr_state_t       state, state_nxt;
  logic [31:0]      rdata;
  logic             unused_addr;

  apb_timer_evt_sync u_sync_lo (.HCLK(HCLK), .HRESETn(HRESETn), .din(event_lo_i), .pulse(lo_pulse));
  apb_timer_evt_sync u_sync_hi (.HCLK(HCLK), .HRESETn(HRESETn), .din(event_hi_i), .pulse(hi_pulse));

  // APB decode; bits [1:0] of the address are don't-care
  logic [2:0] widx;
  logic       acc, bad, wr, rd;
  logic       wr_ctrl, wr_cnt, wr_cmp, wr_st;

  assign widx        = apb.PADDR[4:2];
  assign unused_addr = ^apb.PADDR[1:0];
  assign acc         = apb.PSEL & apb.PENABLE;
  assign bad         = widx > W_STATUS;
  assign wr          = acc & apb.PWRITE & ~bad;
  assign rd          = acc & ~apb.PWRITE & ~bad;
  assign wr_ctrl     = wr & (widx == W_CTRL);
  assign wr_cnt      = wr & (widx == W_CNT);
  assign wr_cmp      = wr & (widx == W_CMP);
  assign wr_st       = wr & (widx == W_STATUS);

`ifdef APB_TIMER_EVT_PRESCALER_EN
  logic [7:0] presc, presc_cnt;

  assign hclk_tick = (presc_cnt == presc);
  assign presc_rd  = presc;

  // Prescaler freezes with the counter; a CNT write restarts the period
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else begin
      if (wr_ctrl) presc <= apb.PWDATA[CTRL_PRESC_LSB +: 8];
      if (wr_cnt) begin
        presc_cnt <= '0;
      end else if (ctrl_en && !stoptimer_i) begin
        presc_cnt <= hclk_tick ? 8'd0 : presc_cnt + 8'd1;
      end
    end
  end
`else
  assign hclk_tick = 1'b1;
  assign presc_rd  = 8'h00;
`endif

  assign tick  = ctrl_src ? lo_pulse : hclk_tick;
  assign count = tick & ctrl_en & ~stoptimer_i;
  assign hit   = count & (cnt == cmp);
  assign wrap  = count & ~hit & (&cnt);

  always_comb begin
    st_set           = '0;
    st_set[ST_MATCH] = hit;
    st_set[ST_OVF]   = wrap;
    st_set[ST_CAPV]  = hi_pulse;
    st_clr           = wr_st ? apb.PWDATA[2:0] : 3'b000;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en      <= 1'b0;
      ctrl_src     <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      cnt          <= '0;
      cmp          <= CMP_RST;
      cap          <= '0;
      status       <= '0;
    end else begin
      if (hit && ctrl_oneshot) ctrl_en <= 1'b0;
      if (wr_ctrl) begin
        ctrl_en      <= apb.PWDATA[CTRL_EN];
        ctrl_src     <= apb.PWDATA[CTRL_SRC];
        ctrl_oneshot <= apb.PWDATA[CTRL_ONESHOT];
        ctrl_irq_en  <= apb.PWDATA[CTRL_IRQ_EN];
      end
      if (wr_cnt) begin
        cnt <= apb.PWDATA[CNT_W-1:0];
      end else if (hit) begin
        cnt <= '0;
      end else if (count) begin
        cnt <= cnt + CNT_ONE;
      end
      if (wr_cmp) cmp <= apb.PWDATA[CNT_W-1:0];
      if (hi_pulse) cap <= cnt;
      // Hardware set wins over a same-cycle W1C
      status <= (status & ~st_clr) | st_set;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_en) state_nxt = RUN;
      RUN:     if (stoptimer_i) state_nxt = HALT;
      HALT:    if (!stoptimer_i) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!ctrl_en) state_nxt = IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
      irq_q  <= ctrl_irq_en & (status[ST_MATCH] | status[ST_OVF]);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (widx)
        W_CTRL:   rdata = {16'h0000, presc_rd, 4'h0, ctrl_irq_en, ctrl_oneshot, ctrl_src, ctrl_en};
        W_CNT:    rdata[CNT_W-1:0] = cnt;
        W_CMP:    rdata[CNT_W-1:0] = cmp;
        W_CAP:    rdata[CNT_W-1:0] = cap;
        W_STATUS: rdata[2:0] = status;
        default:  rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = acc & bad;
  assign busy_o      = busy_q;
  assign irq_o       = irq_q;

endmodule
